vregfile_sb: RTL and testbench

VREGFILE_SB -- requirements
Module: vregfile_sb

---
 rtl/vregfile_sb.sv | 141 ++++++++++++++
 tb/tb_vregfile_sb.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/vregfile_sb.sv
// Register file with per-register scoreboard busy bits and a sequential dump stream.
// Optional macro VREGFILE_BYPASS_EN forwards same-cycle write data to the read ports.
module vregfile_sb #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 32,
    parameter int NUM_RD     = 2,
    parameter int ZERO_REG   = 1,
    localparam int AW        = $clog2(NUM_REGS)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_RD*AW-1:0]         rd_addr_i,
    output logic [NUM_RD*DATA_WIDTH-1:0] rd_data_o,
    output logic [NUM_RD-1:0]            rd_busy_o,
    input  logic                         wr_en_i,
    input  logic [AW-1:0]                wr_addr_i,
    input  logic [DATA_WIDTH-1:0]        wr_data_i,
    input  logic                         rsv_en_i,
    input  logic [AW-1:0]                rsv_addr_i,
    input  logic                         dump_start_i,
    output logic                         dump_busy_o,
    output logic                         dump_valid_o,
    output logic [AW-1:0]                dump_idx_o,
    output logic [DATA_WIDTH-1:0]        dump_data_o,
    output logic                         dump_done_o
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    localparam logic [AW-1:0] LastIdx = AW'(NUM_REGS - 1);

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
    logic [NUM_REGS-1:0]   busy_q, busy_d;

    state_e        state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic          valid_q, valid_d;
    logic          done_q, done_d;
    logic          dbusy_q, dbusy_d;

    logic wr_ok, rsv_ok;

    // Register 0 is hard-wired when ZERO_REG is set: no writes, no reservations.
    assign wr_ok  = wr_en_i && !((ZERO_REG != 0) && (wr_addr_i == '0));
    assign rsv_ok = rsv_en_i && !((ZERO_REG != 0) && (rsv_addr_i == '0));

    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        if (wr_ok) begin
            regs_d[wr_addr_i] = wr_data_i;
            busy_d[wr_addr_i] = 1'b0;
        end
        // Applied after the write so a same-address reservation wins.
        if (rsv_ok) begin
            busy_d[rsv_addr_i] = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        valid_d = 1'b0;
        done_d  = 1'b0;
        dbusy_d = 1'b0;
        case (state_q)
            StIdle: begin
                if (dump_start_i) begin
                    state_d = StRun;
                    idx_d   = '0;
                    valid_d = 1'b1;
                    dbusy_d = 1'b1;
                end
            end
            StRun: begin
                dbusy_d = 1'b1;
                if (idx_q == LastIdx) begin
                    state_d = StDone;
                    idx_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    valid_d = 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q  <= '{default: '0};
            busy_q  <= '0;
            state_q <= StIdle;
            idx_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            dbusy_q <= 1'b0;
        end else begin
            regs_q  <= regs_d;
            busy_q  <= busy_d;
            state_q <= state_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            dbusy_q <= dbusy_d;
        end
    end

    assign dump_busy_o  = dbusy_q;
    assign dump_valid_o = valid_q;
    assign dump_idx_o   = idx_q;
    assign dump_done_o  = done_q;
    // Stored contents as of this cycle, so earlier writes show up in the stream.
    assign dump_data_o  = valid_q ? regs_q[idx_q] : '0;

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        logic [AW-1:0] addr;
        logic          zero_hit;
        assign addr     = rd_addr_i[g*AW +: AW];
        assign zero_hit = (ZERO_REG != 0) && (addr == '0);
`ifdef VREGFILE_BYPASS_EN
        logic byp;
        assign byp = wr_ok && (wr_addr_i == addr);
        assign rd_data_o[g*DATA_WIDTH +: DATA_WIDTH] =
            zero_hit ? '0 : (byp ? wr_data_i : regs_q[addr]);
        assign rd_busy_o[g] = byp ? (rsv_ok && (rsv_addr_i == addr)) : busy_q[addr];
`else
        assign rd_data_o[g*DATA_WIDTH +: DATA_WIDTH] = zero_hit ? '0 : regs_q[addr];
        assign rd_busy_o[g] = busy_q[addr];
`endif
    end

endmodule

// File: tb/tb_vregfile_sb.sv
// Directed and random bench for vregfile_sb against an array-based reference model.
module tb_vregfile_sb;
    localparam int DW  = 32;
    localparam int NR  = 32;
    localparam int NRD = 2;
    localparam int AW  = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic [NRD*AW-1:0] rd_addr_i;
    logic [NRD*DW-1:0] rd_data_o;
    logic [NRD-1:0]    rd_busy_o;
    logic              wr_en_i;
    logic [AW-1:0]     wr_addr_i;
    logic [DW-1:0]     wr_data_i;
    logic              rsv_en_i;
    logic [AW-1:0]     rsv_addr_i;
    logic              dump_start_i;
    logic              dump_busy_o, dump_valid_o, dump_done_o;
    logic [AW-1:0]     dump_idx_o;
    logic [DW-1:0]     dump_data_o;

    always #5 clk = ~clk;

    vregfile_sb #(.DATA_WIDTH(DW), .NUM_REGS(NR), .NUM_RD(NRD), .ZERO_REG(1)) dut (
        .clk          (clk),
        .rst          (rst),
        .rd_addr_i    (rd_addr_i),
        .rd_data_o    (rd_data_o),
        .rd_busy_o    (rd_busy_o),
        .wr_en_i      (wr_en_i),
        .wr_addr_i    (wr_addr_i),
        .wr_data_i    (wr_data_i),
        .rsv_en_i     (rsv_en_i),
        .rsv_addr_i   (rsv_addr_i),
        .dump_start_i (dump_start_i),
        .dump_busy_o  (dump_busy_o),
        .dump_valid_o (dump_valid_o),
        .dump_idx_o   (dump_idx_o),
        .dump_data_o  (dump_data_o),
        .dump_done_o  (dump_done_o)
    );

    // Reference state: register values, busy flags, and dump progress
    // (0 idle, k in 1..NR visiting index k-1, NR+1 done beat).
    logic [DW-1:0] m_reg  [NR];
    logic          m_busy [NR];
    int            m_cnt;
    int            checks = 0;
    int            errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NR; i++) begin
            m_reg[i]  = '0;
            m_busy[i] = 1'b0;
        end
        m_cnt = 0;
    endtask

    task automatic idle();
        wr_en_i = 0; wr_addr_i = '0; wr_data_i = '0;
        rsv_en_i = 0; rsv_addr_i = '0; dump_start_i = 0;
        rd_addr_i = '0;
    endtask

    task automatic set_rd(input int p, input int a);
        rd_addr_i[p*AW +: AW] = AW'(a);
    endtask

    // Check all outputs mid-cycle against the model, then advance one clock.
    task automatic step();
        int a, idx;
        logic [DW-1:0] ed;
        logic eb, hit;
        @(negedge clk);
        for (int p = 0; p < NRD; p++) begin
            a   = int'(rd_addr_i[p*AW +: AW]);
            hit = 1'b0;
`ifdef VREGFILE_BYPASS_EN
            hit = wr_en_i && (int'(wr_addr_i) == a) && (a != 0);
`endif
            ed = hit ? wr_data_i : ((a == 0) ? '0 : m_reg[a]);
            eb = hit ? (rsv_en_i && (int'(rsv_addr_i) == a)) : m_busy[a];
            chk($sformatf("rd_data[%0d]@%0d", p, a), 64'(rd_data_o[p*DW +: DW]), 64'(ed));
            chk($sformatf("rd_busy[%0d]@%0d", p, a), 64'(rd_busy_o[p]), 64'(eb));
        end
        idx = (m_cnt >= 1 && m_cnt <= NR) ? m_cnt - 1 : 0;
        chk("dump_busy", 64'(dump_busy_o), 64'(m_cnt != 0));
        chk("dump_valid", 64'(dump_valid_o), 64'(m_cnt >= 1 && m_cnt <= NR));
        chk("dump_done", 64'(dump_done_o), 64'(m_cnt == NR + 1));
        chk("dump_idx", 64'(dump_idx_o), 64'(idx));
        chk("dump_data", 64'(dump_data_o), (m_cnt >= 1 && m_cnt <= NR) ? 64'(m_reg[idx]) : 64'd0);
        @(posedge clk);
        if (rst) begin
            model_clear();
        end else begin
            if (wr_en_i && wr_addr_i != 0) begin
                m_reg[wr_addr_i]  = wr_data_i;
                m_busy[wr_addr_i] = 1'b0;
            end
            if (rsv_en_i && rsv_addr_i != 0) m_busy[rsv_addr_i] = 1'b1;
            if (m_cnt == 0) m_cnt = dump_start_i ? 1 : 0;
            else if (m_cnt == NR + 1) m_cnt = 0;
            else m_cnt++;
        end
        #1;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        model_clear();
        @(posedge clk); #1;
        step();                                    // reset state
        rst = 1'b0;

        // Write then read reg 5 on port 1
        wr_en_i = 1; wr_addr_i = 5; wr_data_i = 32'hDEADBEEF; set_rd(1, 5);
        step();
        wr_en_i = 0;
        step();
        chk("req027_rd1", 64'(rd_data_o[DW +: DW]), 64'h0000_0000_DEAD_BEEF);

        // Register 0 ignores writes and reservations
        wr_en_i = 1; wr_addr_i = 0; wr_data_i = 32'h12345678; rsv_en_i = 1; rsv_addr_i = 0;
        set_rd(0, 0);
        step();
        idle();
        step();
        chk("req028_zero", 64'(rd_data_o[DW-1:0]), 64'd0);
        chk("req028_busy", 64'(rd_busy_o[0]), 64'd0);

        // Reserve 7, write it three cycles later; then same-cycle reserve+write
        rsv_en_i = 1; rsv_addr_i = 7; set_rd(0, 7);
        step();
        rsv_en_i = 0;
        step(); step();
        wr_en_i = 1; wr_addr_i = 7; wr_data_i = 32'h0000_7777;
        step();
        wr_en_i = 0;
        step();
        chk("req029_cleared", 64'(rd_busy_o[0]), 64'd0);
        wr_en_i = 1; rsv_en_i = 1; rsv_addr_i = 7; wr_data_i = 32'h0000_8888;
        step();
        wr_en_i = 0; rsv_en_i = 0;
        step();
        chk("req029_rsv_wins", 64'(rd_busy_o[0]), 64'd1);

        // Same-cycle write/read of reg 3 on port 0
        idle();
        wr_en_i = 1; wr_addr_i = 3; wr_data_i = 32'h11111111;
        step();
        wr_data_i = 32'hA5A5A5A5; set_rd(0, 3);
        step();
        idle();

        // Full dump with a write ahead of the cursor and a mid-dump restart
        dump_start_i = 1;
        step();
        dump_start_i = 0;
        for (int c = 0; c < NR + 3; c++) begin
            dump_start_i = (c == 5);
            wr_en_i      = (c == 2);
            wr_addr_i    = 20;
            wr_data_i    = 32'hCAFE0020;
            set_rd(1, c % NR);
            step();
        end
        idle();

        // Reset in the middle of a dump, at index 10
        for (int i = 1; i < NR; i++) begin
            wr_en_i = 1; wr_addr_i = AW'(i); wr_data_i = $urandom;
            rsv_en_i = (i % 3 == 0); rsv_addr_i = AW'(i);
            step();
        end
        idle();
        dump_start_i = 1;
        step();
        dump_start_i = 0;
        for (int c = 0; c < 10; c++) step();
        chk("req032_at_idx", 64'(dump_idx_o), 64'd10);
        rst = 1;
        step();
        rst = 0;
        for (int i = 0; i < NR; i++) begin
            set_rd(0, i);
            set_rd(1, (i + 1) % NR);
            step();
        end

        // Randomised traffic
        for (int n = 0; n < 600; n++) begin
            rst          = ($urandom_range(0, 199) == 0);
            wr_en_i      = $urandom_range(0, 1) == 1;
            wr_addr_i    = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
            wr_data_i    = $urandom;
            rsv_en_i     = $urandom_range(0, 2) == 0;
            rsv_addr_i   = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
            dump_start_i = $urandom_range(0, 15) == 0;
            set_rd(0, $urandom_range(0, 7));
            set_rd(1, ($urandom_range(0, 1) == 1) ? int'(wr_addr_i) : $urandom_range(0, NR - 1));
            step();
        end
        rst = 0;
        idle();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
